ccff_chain_loader: RTL

- Sequences serial loading of one configuration-chain segment (ccff_head → … → ccff_tail), e.g. a ble4 LUT4 + output-mux chain of 18 bits.
- Accepts configuration words from an upstream bitstream source over a valid/ready handshake and serialises them LSB-first onto ccff_head.
- Drives a shift enable that an external clock gate (ICG) uses to gate prog_clk to the chain.
- Optional verify pass compares the bits emerging on ccff_tail against the bits being shifted in, so a re-sent identical stream proves the chain.

---
 rtl/ccff_ctrl_pkg.sv | 17 +
 rtl/ccff_word_serializer.sv | 44 ++++
 rtl/ccff_chain_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ccff_ctrl_pkg.sv
// Shared types and helpers for the configuration-chain loader.
// Holds the sequencer state encoding and the counter width helper.
package ccff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bits needed to hold any count from 0 up to and including max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer: loads a word with a bit count, then presents bit 0
// first and shifts right once per shift_i until the count is exhausted.
module ccff_word_serializer
  import ccff_ctrl_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     shift_i,
  input  logic [WORD_W-1:0]        data_i,
  input  logic [cnt_w(WORD_W)-1:0] len_i,
  output logic                     bit_o,
  output logic                     last_o,
  output logic                     empty_o
);

  localparam int NB_W = cnt_w(WORD_W);

  logic [WORD_W-1:0] shreg_q;
  logic [NB_W-1:0]   nbits_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values. The shift register is reset as well because
  // its bit 0 drives the chain input directly and must read 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      nbits_q <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
      nbits_q <= len_i;
    end else if (shift_i && (nbits_q != '0)) begin
      shreg_q <= shreg_q >> 1;
      nbits_q <= nbits_q - NB_W'(1);
    end
  end

  assign bit_o   = shreg_q[0];
  assign last_o  = (nbits_q == NB_W'(1));
  assign empty_o = (nbits_q == '0);

endmodule

// File: rtl/ccff_chain_loader.sv
// Sequences one serial load (optionally with tail verify) of a configuration
// chain segment from a valid/ready word stream, gating prog_clk via chain_clk_en.
module ccff_chain_loader
  import ccff_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 18,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_clk_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BL_W = cnt_w(CHAIN_LEN);
  localparam int NB_W = cnt_w(WORD_W);

  state_e          state_q;
  logic [BL_W-1:0] bits_left_q;
  logic            verify_q;
  logic            cfg_ready_q;
  logic            chain_clk_en_q;
  logic            busy_q;
  logic            done_q;
  logic            error_q;

  logic [NB_W-1:0] load_len;
  logic            ser_load;
  logic            ser_bit;
  logic            ser_last;
  logic            ser_empty;

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    load_len = NB_W'(WORD_W);
    if (int'(bits_left_q) < WORD_W) load_len = NB_W'(bits_left_q);
  end

  assign ser_load = cfg_ready_q && cfg_valid && ser_empty;

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk     (prog_clk),
    .rst_n   (reset),
    .load_i  (ser_load),
    .shift_i (chain_clk_en_q),
    .data_i  (cfg_data),
    .len_i   (load_len),
    .bit_o   (ser_bit),
    .last_o  (ser_last),
    .empty_o (ser_empty)
  );

  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      bits_left_q    <= '0;
      verify_q       <= 1'b0;
      cfg_ready_q    <= 1'b0;
      chain_clk_en_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Chain is FIFO: before shift i the tail holds bit i of the prior pass.
      if (verify_q && chain_clk_en_q && (ccff_tail != ser_bit)) error_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= FETCH;
            busy_q      <= 1'b1;
            cfg_ready_q <= 1'b1;
            error_q     <= 1'b0;
            verify_q    <= verify;
            bits_left_q <= BL_W'(CHAIN_LEN);
          end
        end
        FETCH: begin
          if (cfg_valid && ser_empty) begin
            state_q        <= SHIFT;
            cfg_ready_q    <= 1'b0;
            chain_clk_en_q <= 1'b1;
          end
        end
        SHIFT: begin
          bits_left_q <= bits_left_q - BL_W'(1);
          if (ser_last) begin
            chain_clk_en_q <= 1'b0;
            if (bits_left_q == BL_W'(1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q     <= FETCH;
              cfg_ready_q <= 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign chain_clk_en = chain_clk_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign ccff_head    = ser_bit;

endmodule
